// File: rtl/periodic_wave_scheduler_pkg.sv
// Shared FSM encoding and constants for the periodic wave scheduler.
package periodic_wave_scheduler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

  localparam int DEFAULT_CYCLES_PER_MS = 50_000;
  localparam int MIN_PERIOD            = 2;

endpackage

// File: rtl/periodic_wave_scheduler_wave_channel.sv
// One square-wave channel stepped by the shared millisecond tick.
// wave/rising_edge are registered from the next counter state, so they move one cycle after a tick.
module wave_channel #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    enable,
  output logic                    wave,
  output logic                    rising_edge
);

  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] period_d;
  logic                    enable_q;
  logic                    enable_d;
  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic [PERIOD_WIDTH-1:0] cnt_d;
  logic                    wave_d;

  // A load only ever arrives in a tick cycle and replaces the advance with a phase restart.
  always_comb begin
    period_d = period_q;
    enable_d = enable_q;
    cnt_d    = cnt_q;
    if (load) begin
      period_d = period;
      enable_d = enable;
      cnt_d    = '0;
    end else if (!enable_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == period_q - 1'b1) ? '0 : cnt_q + 1'b1;
    end
    wave_d = enable_d && (cnt_d >= (period_d >> 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period_q    <= '0;
      enable_q    <= 1'b0;
      cnt_q       <= '0;
      wave        <= 1'b0;
      rising_edge <= 1'b0;
    end else begin
      period_q    <= period_d;
      enable_q    <= enable_d;
      cnt_q       <= cnt_d;
      wave        <= wave_d;
      rising_edge <= wave_d && !wave;
    end
  end

endmodule

// File: rtl/periodic_wave_scheduler.sv
// Multi-channel square-wave scheduler sharing one millisecond prescaler.
// Config requests wait for the next tick_ms (up to CYCLES_PER_MS+1 cycles); cfg_ready is low meanwhile.
module periodic_wave_scheduler
  import periodic_wave_scheduler_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CYCLES_PER_MS = DEFAULT_CYCLES_PER_MS,
  parameter int PERIOD_WIDTH  = 16,
  parameter int CH_WIDTH      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_WIDTH-1:0]     cfg_channel,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic                    cfg_enable,
  output logic                    cfg_error,
  output logic                    tick_ms,
  output logic [CHANNELS-1:0]     wave,
  output logic [CHANNELS-1:0]     rising_edge
);

  localparam int PRE_WIDTH = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(CYCLES_PER_MS - 1);

  typedef struct packed {
    logic [CH_WIDTH-1:0]     channel;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    enable;
  } cfg_req_t;

  logic [PRE_WIDTH-1:0] pre_q;
  cfg_state_e           state_q;
  cfg_state_e           state_d;
  cfg_req_t             req_q;
  cfg_req_t             req_d;
  logic                 error_d;
  logic                 req_bad;
  logic                 load;

  assign tick_ms = (pre_q == PRE_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick_ms ? '0 : pre_q + 1'b1;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  // A disable request carries no meaningful period, so only enables are range-checked.
  assign req_bad   = (32'(cfg_channel) >= CHANNELS) ||
                     (cfg_enable && (32'(cfg_period) < MIN_PERIOD));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    error_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (req_bad) begin
            error_d = 1'b1;
          end else begin
            req_d.channel = cfg_channel;
            req_d.period  = cfg_period;
            req_d.enable  = cfg_enable;
            state_d       = PENDING;
          end
        end
      end
      PENDING: begin
        if (tick_ms) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cfg_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cfg_error <= error_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wave_channel #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick_ms),
      .load        (load && (req_q.channel == CH_WIDTH'(i))),
      .period      (req_q.period),
      .enable      (req_q.enable),
      .wave        (wave[i]),
      .rising_edge (rising_edge[i])
    );
  end

endmodule

// File: tb/tb_periodic_wave_scheduler.sv
// Bench for periodic_wave_scheduler: directed scenarios plus random config traffic against a phase-arithmetic model.
module tb_periodic_wave_scheduler;

  localparam int CHANNELS = 4;
  localparam int CPM      = 4;
  localparam int PW       = 16;
  localparam int CW       = 3;

  logic                clock = 1'b0;
  logic                reset;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CW-1:0]       cfg_channel;
  logic [PW-1:0]       cfg_period;
  logic                cfg_enable;
  logic                cfg_error;
  logic                tick_ms;
  logic [CHANNELS-1:0] wave;
  logic [CHANNELS-1:0] rising_edge;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  periodic_wave_scheduler #(
    .CHANNELS      (CHANNELS),
    .CYCLES_PER_MS (CPM),
    .PERIOD_WIDTH  (PW),
    .CH_WIDTH      (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_channel (cfg_channel),
    .cfg_period  (cfg_period),
    .cfg_enable  (cfg_enable),
    .cfg_error   (cfg_error),
    .tick_ms     (tick_ms),
    .wave        (wave),
    .rising_edge (rising_edge)
  );

  // Model: cycle 1 is the first cycle after reset; tick k lands in cycle k*CPM.
  // A channel configured on tick a shows phase ((ticks seen) - a) mod P from the next cycle.
  int                  cyc = 0;
  bit                  m_en    [CHANNELS];
  int                  m_per   [CHANNELS];
  int                  m_apply [CHANNELS];
  bit                  p_valid;
  bit                  p_en;
  int                  p_ch;
  int                  p_per;
  int                  p_apply;
  logic [CHANNELS-1:0] exp_wave;
  logic [CHANNELS-1:0] exp_rise;
  logic                exp_tick;
  logic                exp_ready;
  logic                exp_err;

  task automatic model_clear();
    for (int i = 0; i < CHANNELS; i++) begin
      m_en[i]    = 1'b0;
      m_per[i]   = 0;
      m_apply[i] = 0;
    end
    p_valid   = 1'b0;
    exp_wave  = '0;
    exp_rise  = '0;
    exp_tick  = 1'b0;
    exp_ready = 1'b1;
    exp_err   = 1'b0;
  endtask

  task automatic model_eval();
    int n;
    logic [CHANNELS-1:0] prev;
    n = (cyc - 1) / CPM;
    if (p_valid && n >= p_apply) begin
      m_en[p_ch]    = p_en;
      m_per[p_ch]   = p_per;
      m_apply[p_ch] = p_apply;
      p_valid       = 1'b0;
    end
    prev = exp_wave;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      exp_wave[ch] = 1'b0;
      if (m_en[ch]) exp_wave[ch] = (((n - m_apply[ch]) % m_per[ch]) >= (m_per[ch] / 2));
    end
    exp_rise  = exp_wave & ~prev;
    exp_tick  = ((cyc % CPM) == 0);
    exp_ready = !p_valid;
  endtask

  task automatic step();
    bit err_n;
    err_n = 1'b0;
    if (!reset && cfg_valid && exp_ready) begin
      if (int'(cfg_channel) >= CHANNELS || (cfg_enable && int'(cfg_period) < 2)) begin
        err_n = 1'b1;
      end else begin
        p_valid = 1'b1;
        p_ch    = int'(cfg_channel);
        p_per   = int'(cfg_period);
        p_en    = cfg_enable;
        p_apply = cyc / CPM + 1;
      end
    end
    @(posedge clock);
    #1;
    if (reset) begin
      model_clear();
      cyc = 1;
    end else begin
      cyc++;
    end
    model_eval();
    exp_err = err_n;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    repeat (2) step();
    tests_run++;
    if ({wave, rising_edge, tick_ms, cfg_error} !== '0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_values wave=%b rise=%b tick=%b err=%b ready=%b, want all 0 and ready=1",
               wave, rising_edge, tick_ms, cfg_error, cfg_ready);
    end
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tests_run++;
      if (tick_ms !== ((k % CPM) == 0) || wave !== '0 || rising_edge !== '0 || cfg_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_release cycle=%0d tick=%b want %b wave=%b rise=%b ready=%b",
                 k, tick_ms, ((k % CPM) == 0), wave, rising_edge, cfg_ready);
      end
      step();
    end
  endtask

  task automatic test_ch0_period4();
    int last;
    last        = -1;
    cfg_channel = 3'd0;
    cfg_period  = 16'd4;
    cfg_enable  = 1'b1;
    cfg_valid   = 1'b1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ch0_ready_before got %b want 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tests_run++;
      if (wave !== exp_wave || rising_edge !== exp_rise || tick_ms !== exp_tick ||
          cfg_ready !== exp_ready || cfg_error !== exp_err) begin
        tests_failed++;
        $display("FAIL ch0_p4 cyc=%0d wave=%b/%b rise=%b/%b tick=%b/%b ready=%b/%b err=%b/%b", cyc,
                 wave, exp_wave, rising_edge, exp_rise, tick_ms, exp_tick, cfg_ready, exp_ready, cfg_error, exp_err);
      end
      if (rising_edge[0] === 1'b1) begin
        tests_run++;
        if (wave[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL ch0_rise_align cyc=%0d wave0=%b want 1", cyc, wave[0]);
        end
        if (last >= 0) begin
          tests_run++;
          if (cyc - last != 16) begin
            tests_failed++;
            $display("FAIL ch0_rise_spacing got %0d cycles want 16", cyc - last);
          end
        end
        last = cyc;
      end
      step();
    end
    tests_run++;
    if (last < 0) begin
      tests_failed++;
      $display("FAIL ch0_no_rise got no rising_edge[0] want at least one");
    end
  endtask

  task automatic test_ch1_period3();
    int last;
    last        = -1;
    cfg_channel = 3'd1;
    cfg_period  = 16'd3;
    cfg_enable  = 1'b1;
    cfg_valid   = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 48; k++) begin
      tests_run++;
      if (wave !== exp_wave || rising_edge !== exp_rise || tick_ms !== exp_tick ||
          cfg_ready !== exp_ready || cfg_error !== exp_err) begin
        tests_failed++;
        $display("FAIL ch1_p3 cyc=%0d wave=%b/%b rise=%b/%b tick=%b/%b ready=%b/%b err=%b/%b", cyc,
                 wave, exp_wave, rising_edge, exp_rise, tick_ms, exp_tick, cfg_ready, exp_ready, cfg_error, exp_err);
      end
      if (rising_edge[1] === 1'b1) begin
        if (last >= 0) begin
          tests_run++;
          if (cyc - last != 12) begin
            tests_failed++;
            $display("FAIL ch1_rise_spacing got %0d cycles want 12", cyc - last);
          end
        end
        last = cyc;
      end
      step();
    end
  endtask

  task automatic test_invalid();
    cfg_valid   = 1'b1;
    cfg_channel = 3'd5;
    cfg_period  = 16'd4;
    cfg_enable  = 1'b1;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_error !== 1'b1 || cfg_ready !== 1'b1 || wave !== exp_wave) begin
      tests_failed++;
      $display("FAIL bad_channel err=%b want 1 ready=%b want 1 wave=%b want %b", cfg_error, cfg_ready, wave, exp_wave);
    end
    step();
    tests_run++;
    if (cfg_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_channel_pulse err=%b want 0", cfg_error);
    end
    cfg_valid   = 1'b1;
    cfg_channel = 3'd2;
    cfg_period  = 16'd1;
    cfg_enable  = 1'b1;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_error !== 1'b1 || cfg_ready !== 1'b1 || wave !== exp_wave) begin
      tests_failed++;
      $display("FAIL short_period err=%b want 1 ready=%b want 1 wave=%b want %b", cfg_error, cfg_ready, wave, exp_wave);
    end
    step();
    tests_run++;
    if (cfg_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_period_pulse err=%b want 0", cfg_error);
    end
    cfg_valid   = 1'b1;
    cfg_channel = 3'd3;
    cfg_period  = 16'd0;
    cfg_enable  = 1'b0;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_ready !== 1'b0 || cfg_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable_p0 ready=%b want 0 err=%b want 0", cfg_ready, cfg_error);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      tests_run++;
      if (wave !== exp_wave || rising_edge !== exp_rise || cfg_ready !== exp_ready || cfg_error !== exp_err) begin
        tests_failed++;
        $display("FAIL invalid_after cyc=%0d wave=%b/%b rise=%b/%b ready=%b/%b err=%b/%b", cyc,
                 wave, exp_wave, rising_edge, exp_rise, cfg_ready, exp_ready, cfg_error, exp_err);
      end
    end
  endtask

  task automatic test_tick_request();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (exp_tick && exp_wave[0] && exp_ready) found = 1'b1;
      else step();
    end
    tests_run++;
    if (!found || tick_ms !== 1'b1 || wave[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL tick_req_setup found=%0d tick=%b wave0=%b want 1/1/1", found, tick_ms, wave[0]);
    end
    cfg_valid   = 1'b1;
    cfg_channel = 3'd0;
    cfg_period  = 16'd0;
    cfg_enable  = 1'b0;
    step();
    cfg_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tests_run++;
      if (cfg_ready !== 1'b0 || rising_edge[0] !== 1'b0 || tick_ms !== (j == 4)) begin
        tests_failed++;
        $display("FAIL tick_req_pending j=%0d ready=%b want 0 rise0=%b want 0 tick=%b want %b",
                 j, cfg_ready, rising_edge[0], tick_ms, (j == 4));
      end
      step();
    end
    tests_run++;
    if (cfg_ready !== 1'b1 || wave[0] !== 1'b0 || rising_edge[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL tick_req_applied ready=%b want 1 wave0=%b want 0 rise0=%b want 0",
               cfg_ready, wave[0], rising_edge[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cfg_valid   = ($urandom_range(0, 2) == 0);
      cfg_channel = CW'($urandom_range(0, 5));
      cfg_period  = PW'($urandom_range(0, 9));
      cfg_enable  = ($urandom_range(0, 3) != 0);
      step();
      tests_run++;
      if (wave !== exp_wave || rising_edge !== exp_rise || tick_ms !== exp_tick ||
          cfg_ready !== exp_ready || cfg_error !== exp_err) begin
        tests_failed++;
        $display("FAIL random cyc=%0d wave=%b/%b rise=%b/%b tick=%b/%b ready=%b/%b err=%b/%b", cyc,
                 wave, exp_wave, rising_edge, exp_rise, tick_ms, exp_tick, cfg_ready, exp_ready, cfg_error, exp_err);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_pending();
    for (int k = 0; k < 16 && !exp_ready; k++) step();
    cfg_valid   = 1'b1;
    cfg_channel = 3'd2;
    cfg_period  = 16'd5;
    cfg_enable  = 1'b1;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pending_accept ready=%b want 0", cfg_ready);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if ({wave, rising_edge, tick_ms, cfg_error} !== '0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pending_clear wave=%b rise=%b tick=%b err=%b ready=%b", wave, rising_edge, tick_ms, cfg_error, cfg_ready);
    end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tests_run++;
      if (tick_ms !== ((k % CPM) == 0) || wave !== '0 || rising_edge !== '0 || cfg_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_pending_after cycle=%0d tick=%b want %b wave=%b rise=%b ready=%b",
                 k, tick_ms, ((k % CPM) == 0), wave, rising_edge, cfg_ready);
      end
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    cfg_valid   = 1'b0;
    cfg_channel = '0;
    cfg_period  = '0;
    cfg_enable  = 1'b0;
    model_clear();
    test_reset();
    test_ch0_period4();
    test_ch1_period3();
    test_invalid();
    test_tick_request();
    test_random();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/periodic_wave_scheduler.md
Name: periodic_wave_scheduler

Overview:
- Multi-channel square-wave scheduler that shares one millisecond prescaler among CHANNELS independent periodic outputs.
- Each channel is programmed at run time through a valid/ready config port with a period in milliseconds and an enable.
- It replaces per-consumer instances of the fixed-period square wave generator, e.g. blink, refresh and animation timing in the display/GPU front end.
- Config changes apply only on a millisecond boundary, so outputs never glitch.

Parameters:
- CHANNELS, 4: number of independent wave channels (1..8).
- CYCLES_PER_MS, 50_000: clock cycles per millisecond tick (50 MHz clock); benches use 4.
- PERIOD_WIDTH, 16: width of the period field, in ms.
- CH_WIDTH, 2: width of the channel index; must be at least clog2(CHANNELS).

Ports:
- clock, input, 1: system clock (50 MHz).
- reset, input, 1: synchronous, active-high reset.
- cfg_valid, input, 1: config request valid.
- cfg_ready, output, 1: config port can accept a request.
- cfg_channel, input, CH_WIDTH: target channel.
- cfg_period, input, PERIOD_WIDTH: period in ms; legal range 2..2^PERIOD_WIDTH-1.
- cfg_enable, input, 1: 1 = run channel, 0 = stop channel.
- cfg_error, output, 1: one-cycle pulse when a request is rejected.
- tick_ms, output, 1: one-cycle pulse every CYCLES_PER_MS cycles.
- wave, output, CHANNELS: per-channel square wave.
- rising_edge, output, CHANNELS: one-cycle pulse per channel on each wave 0->1 transition.

Behaviour:
- Reset (sync, active-high) takes priority over every other input. It sets:
  - prescaler = 0; all channel counters = 0; all periods = 0; all enables = 0;
  - wave = 0, rising_edge = 0, tick_ms = 0, cfg_error = 0, cfg_ready = 1; FSM = IDLE.
  - Reset asserted mid-transaction discards any pending config.
- Prescaler:
  - Counts 0..CYCLES_PER_MS-1 and wraps to 0.
  - tick_ms = 1 in the cycle the prescaler equals CYCLES_PER_MS-1 (combinational from the register).
  - First tick is CYCLES_PER_MS cycles after reset release.
- Channel counter, for an enabled channel with period P:
  - cnt advances only on tick_ms; cnt = (cnt == P-1) ? 0 : cnt+1.
  - wave = registered (cnt >= P>>1). High time is P - (P>>1) ms; low time is P>>1 ms. Odd P gives the extra ms to the high phase.
  - rising_edge = 1 for exactly one cycle when the registered wave goes 0->1. It is aligned with the cycle the wave register first reads 1, i.e. one cycle after the tick_ms that moved cnt to P>>1.
- Disabled channel: cnt held at 0, wave = 0, rising_edge = 0.
- Config FSM:
  - IDLE: cfg_ready = 1. A transfer happens when cfg_valid && cfg_ready.
    - Request is invalid if cfg_channel >= CHANNELS, or if cfg_enable = 1 and cfg_period < 2.
    - Invalid: drop the request, pulse cfg_error next cycle, stay in IDLE.
    - Valid: latch channel/period/enable, go to PENDING.
  - PENDING: cfg_ready = 0. Wait for tick_ms.
    - In the tick_ms cycle, write period and enable and force that channel's cnt to 0 instead of advancing it.
    - The channel's wave drops or stays at 0 from the next cycle, with no rising_edge.
    - Other channels advance normally in the same cycle. Return to IDLE.
  - Transfer accepted in the same cycle as tick_ms: it waits for the next tick, never the current one.
  - Worst-case config latency is CYCLES_PER_MS+1 cycles.
- Reprogramming a running channel restarts its phase at cnt = 0. A disable request ignores cfg_period, so period 0 is legal there.
- Counter width is PERIOD_WIDTH. No arithmetic overflow is possible because cnt <= P-1.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, PENDING);
  - the DEFAULT_CYCLES_PER_MS = 50_000 constant;
  - the MIN_PERIOD = 2 constant.
- Natural sub-module: wave_channel, instantiated CHANNELS times via generate.
  - Inputs: clock, reset, tick, load, period, enable.
  - Outputs: wave, rising_edge.
- The top level holds the prescaler and the config FSM.

Test Plan (all with CYCLES_PER_MS = 4):
- Reset release: tick_ms first pulses at cycle 4, then every 4 cycles; wave = 0, cfg_ready = 1, no rising_edge until configured.
- Config ch0, P = 4, enable = 1: applied at the next tick. Then wave[0] is low for 2 ms (8 cycles) and high for 2 ms in steady state, and rising_edge[0] pulses once every 16 cycles, aligned with wave[0] rising.
- Config ch1, P = 3: wave[1] is low for 1 ms and high for 2 ms (4 and 8 cycles). Ch0 is unaffected during ch1's apply tick.
- Invalid requests:
  - cfg_channel = 5 with CHANNELS = 4 -> cfg_error pulse one cycle, state unchanged.
  - P = 1 with enable = 1 -> cfg_error pulse one cycle, state unchanged.
  - P = 0 with enable = 0 -> accepted.
- Request on the tick_ms cycle: cfg_ready is 0 for 4 cycles and the update lands on the following tick. A disable of ch0 while wave[0] = 1 drops wave[0] one cycle after that tick, with no rising_edge.
- Reset asserted while PENDING: the pending config is lost, all waves are 0, and the prescaler restarts from 0.
